as_exmem: RTL and testbench
===========================

AS_EXMEM -- requirements
Module: as_exmem

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL come from as_pack (reg_width = 64).
REQ-002 The port clk_i SHALL be an input, 1 bit wide, and SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_i SHALL be an input, 1 bit wide, carrying a synchronous, active-high reset.
REQ-004 The port flush_i SHALL be an input, 1 bit wide, that discards all held and incoming entries.
REQ-005 The input-side ports SHALL be:
- in_valid_i, input, 1 bit: upstream execute stage has an entry.
- in_ready_o, output, 1 bit: this stage can accept an entry.
REQ-006 The input payload ports SHALL be:
- alu_result_i, input, reg_width bits: ALU result.
- alu_zero_i, alu_nega_i, alu_carr_i, alu_over_i, input, 1 bit each: ALU flags Z, N, C, V.
- rd_addr_i, input, 5 bits: destination register.
- reg_we_i, input, 1 bit: register write enable.
- is_branch_i, input, 1 bit: the entry is a conditional branch.
- br_funct3_i, input, 3 bits: branch condition code.
- br_target_i, input, reg_width bits: branch target address.
REQ-007 The output-side ports SHALL be:
- out_valid_o, output, 1 bit: an entry is presented downstream.
- out_ready_i, input, 1 bit: downstream accepts the presented entry.
REQ-008 The output payload ports SHALL be:
- result_o, output, reg_width bits.
- rd_addr_o, output, 5 bits.
- reg_we_o, output, 1 bit.
- br_taken_o, output, 1 bit.
- br_illegal_o, output, 1 bit.
- br_target_o, output, reg_width bits.

Function
REQ-009 An input transfer SHALL occur when in_valid_i && in_ready_o && !flush_i; an output transfer SHALL occur when out_valid_o && out_ready_i.
REQ-010 The block SHALL be a 2-entry skid buffer, made of a main register driving the outputs and a skid register; in_ready_o SHALL equal !skid_valid and SHALL be registered, with no combinational path from out_ready_i.
REQ-011 An accepted entry SHALL go to the main register when main is empty or an output transfer occurs in the same cycle; otherwise it SHALL go to the skid register.
REQ-012 On an output transfer with skid full, the skid entry SHALL move to main in the next cycle.
REQ-013 Latency from input transfer to out_valid_o SHALL be exactly 1 cycle when main is empty or draining.
REQ-014 Entries SHALL leave in acceptance order; none SHALL be dropped or duplicated except by flush_i or rst_i.
REQ-015 While out_valid_o && !out_ready_i, all output payload SHALL be held stable.
REQ-016 Branch evaluation SHALL be done on the input flags at capture time and stored with the entry. Flag semantics: C=1 means no borrow on subtract.
- 000 BEQ: Z
- 001 BNE: !Z
- 100 BLT: N^V
- 101 BGE: !(N^V)
- 110 BLTU: !C
- 111 BGEU: C
REQ-017 When is_branch_i is set and br_funct3_i is 010 or 011, the stored br_taken SHALL be 0 and br_illegal SHALL be 1.
REQ-018 When is_branch_i = 0, the stored br_taken and br_illegal SHALL both be 0.
REQ-019 flush_i SHALL clear both valid bits at the next edge, SHALL block any input transfer in that cycle, and SHALL take priority over every other update.
REQ-020 When out_valid_o = 0, the payload outputs SHALL hold their last value; the verifier SHALL check them only when out_valid_o = 1.

Reset
REQ-021 While rst_i is sampled high, the block SHALL behave as follows:
- Both valid bits SHALL clear.
- All payload registers SHALL go to 0.
- out_valid_o SHALL be 0 and in_ready_o SHALL be 1 after the edge.
- rst_i SHALL override flush_i and the handshakes.
REQ-022 Reset mid-operation SHALL discard held entries, with no output transfer in the reset cycle.

Structure
REQ-023 The shared package as_pack SHALL hold:
- the br_cond_e enum for funct3 codes;
- an exmem_entry_t packed struct (result, rd_addr, reg_we, br_taken, br_illegal, br_target);
- reg_width.
REQ-024 Flag-to-condition evaluation SHALL be a combinational sub-module as_brcond (Z, N, C, V, funct3, is_branch in; taken, illegal out).

Verification
REQ-025 Reset scenario: hold rst_i for 2 cycles with in_valid_i = 1 -> out_valid_o = 0, in_ready_o = 1, result_o = 0; no transfer occurs.
REQ-026 Branch condition scenario: flags Z0 N1 C0 V0 (from 2-4) with funct3 100, 110, 111 in successive cycles and out_ready_i = 1 -> br_taken_o = 1, 1, 0, each one cycle after acceptance.
REQ-027 Signed overflow scenario: flags Z0 N0 C1 V1 (from 0x8000000000000000-2) -> BLT taken = 1, BGE taken = 0, BGEU taken = 1.
REQ-028 Backpressure scenario: out_ready_i = 0 while offering results 0x19, 0x1, 0x5 -> first two accepted, in_ready_o = 0 after the second; then raise out_ready_i -> outputs 0x19, 0x1, 0x5 in order, payload stable while stalled.
REQ-029 Flush scenario: flush_i pulse with both entries held and in_valid_i = 1 -> next cycle out_valid_o = 0, in_ready_o = 1, and the input entry never appears.
REQ-030 Illegal condition scenario: is_branch_i = 1, funct3 010 -> br_illegal_o = 1, br_taken_o = 0; the same entry with is_branch_i = 0 -> both outputs 0.

Source files
------------

// File: rtl/as_pack.sv
// as_pack: shared widths, branch condition codes and the EX/MEM entry layout
package as_pack;
  localparam int reg_width = 64;
  typedef enum logic [2:0] {
    BR_EQ  = 3'b000,
    BR_NE  = 3'b001,
    BR_LT  = 3'b100,
    BR_GE  = 3'b101,
    BR_LTU = 3'b110,
    BR_GEU = 3'b111
  } br_cond_e;
  typedef struct packed {
    logic [reg_width-1:0] result;
    logic [4:0]           rd_addr;
    logic                 reg_we;
    logic                 br_taken;
    logic                 br_illegal;
    logic [reg_width-1:0] br_target;
  } exmem_entry_t;
endpackage

// File: rtl/as_brcond.sv
// as_brcond: resolves a branch condition from ALU flags (C=1 means no borrow)
module as_brcond
  import as_pack::*;
(
  input  logic       zero_i,
  input  logic       nega_i,
  input  logic       carr_i,
  input  logic       over_i,
  input  logic [2:0] funct3_i,
  input  logic       is_branch_i,
  output logic       taken_o,
  output logic       illegal_o
);
  // codes 010/011 are not branch conditions; they never resolve as taken
  always_comb begin
    illegal_o = is_branch_i && (funct3_i[2:1] == 2'b01);
    taken_o = 1'b0;
    case (br_cond_e'(funct3_i))
      BR_EQ:   taken_o = is_branch_i && zero_i;
      BR_NE:   taken_o = is_branch_i && !zero_i;
      BR_LT:   taken_o = is_branch_i && (nega_i ^ over_i);
      BR_GE:   taken_o = is_branch_i && !(nega_i ^ over_i);
      BR_LTU:  taken_o = is_branch_i && !carr_i;
      BR_GEU:  taken_o = is_branch_i && carr_i;
      default: taken_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/as_exmem.sv
// as_exmem: EX/MEM pipeline register as a 2-entry skid buffer with branch resolution at capture
module as_exmem
  import as_pack::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [reg_width-1:0] alu_result_i,
  input  logic                 alu_zero_i,
  input  logic                 alu_nega_i,
  input  logic                 alu_carr_i,
  input  logic                 alu_over_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 reg_we_i,
  input  logic                 is_branch_i,
  input  logic [2:0]           br_funct3_i,
  input  logic [reg_width-1:0] br_target_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [reg_width-1:0] result_o,
  output logic [4:0]           rd_addr_o,
  output logic                 reg_we_o,
  output logic                 br_taken_o,
  output logic                 br_illegal_o,
  output logic [reg_width-1:0] br_target_o
);
  exmem_entry_t main_q, main_d, skid_q, skid_d, in_entry;
  logic main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic taken, illegal, in_xfer, out_xfer;
  as_brcond u_brcond (
    .zero_i     (alu_zero_i),
    .nega_i     (alu_nega_i),
    .carr_i     (alu_carr_i),
    .over_i     (alu_over_i),
    .funct3_i   (br_funct3_i),
    .is_branch_i(is_branch_i),
    .taken_o    (taken),
    .illegal_o  (illegal)
  );
  assign in_entry = '{result: alu_result_i, rd_addr: rd_addr_i, reg_we: reg_we_i,
                      br_taken: taken, br_illegal: illegal, br_target: br_target_i};
  assign in_ready_o = !skid_valid_q;
  assign in_xfer = in_valid_i && in_ready_o && !flush_i;
  assign out_xfer = main_valid_q && out_ready_i;
  assign out_valid_o = main_valid_q;
  assign result_o = main_q.result;
  assign rd_addr_o = main_q.rd_addr;
  assign reg_we_o = main_q.reg_we;
  assign br_taken_o = main_q.br_taken;
  assign br_illegal_o = main_q.br_illegal;
  assign br_target_o = main_q.br_target;
  // refill main from skid first (older), else from input; park input in skid while main stalls
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_xfer || !main_valid_q) begin
      main_valid_d = skid_valid_q || in_xfer;
      main_d = skid_valid_q ? skid_q : in_xfer ? in_entry : main_q;
      skid_valid_d = 1'b0;
    end else if (in_xfer) begin
      skid_d = in_entry;
      skid_valid_d = 1'b1;
    end
  end
  // state registers; reset clears valids and payload
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_q <= '0;
      skid_q <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end
endmodule

// File: tb/tb_as_exmem.sv
// tb_as_exmem: directed scoreboard bench for the EX/MEM skid buffer
module tb_as_exmem;
  import as_pack::*;
  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [63:0] alu_result, br_target, result, br_target_o;
  logic z, n, c, v, reg_we, is_branch, reg_we_o, br_taken, br_illegal;
  logic [4:0] rd_addr, rd_addr_o;
  logic [2:0] funct3;
  int n_cmp = 0;
  int n_err = 0;
  bit known = 0;
  exmem_entry_t sb[$];
  exmem_entry_t pend;

  always #5 clk = ~clk;

  as_exmem dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .alu_result_i(alu_result), .alu_zero_i(z), .alu_nega_i(n), .alu_carr_i(c), .alu_over_i(v),
    .rd_addr_i(rd_addr), .reg_we_i(reg_we), .is_branch_i(is_branch),
    .br_funct3_i(funct3), .br_target_i(br_target),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .result_o(result), .rd_addr_o(rd_addr_o), .reg_we_o(reg_we_o),
    .br_taken_o(br_taken), .br_illegal_o(br_illegal), .br_target_o(br_target_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic offer(input logic [63:0] res, input logic [4:0] rd, input logic isb,
                       input logic [2:0] f3, input logic [3:0] znzv,
                       input logic exp_taken, input logic exp_ill);
    in_valid = 1'b1;
    alu_result = res;
    rd_addr = rd;
    reg_we = ~isb;
    is_branch = isb;
    funct3 = f3;
    {z, n, c, v} = znzv;
    br_target = res ^ 64'hA5A5_0000_0000_1234;
    pend = '{result: res, rd_addr: rd, reg_we: ~isb, br_taken: exp_taken,
             br_illegal: exp_ill, br_target: res ^ 64'hA5A5_0000_0000_1234};
  endtask

  task automatic tick();
    bit do_in, do_out;
    @(negedge clk);
    if (known) begin
      chk("out_valid", 64'(out_valid), 64'(sb.size() > 0));
      chk("in_ready", 64'(in_ready), 64'(sb.size() < 2));
      if (out_valid === 1'b1 && sb.size() > 0) begin
        chk("result", result, sb[0].result);
        chk("rd_addr", 64'(rd_addr_o), 64'(sb[0].rd_addr));
        chk("reg_we", 64'(reg_we_o), 64'(sb[0].reg_we));
        chk("br_taken", 64'(br_taken), 64'(sb[0].br_taken));
        chk("br_illegal", 64'(br_illegal), 64'(sb[0].br_illegal));
        chk("br_target", br_target_o, sb[0].br_target);
      end
    end
    do_out = sb.size() > 0 && out_ready;
    do_in = in_valid && sb.size() < 2 && !flush;
    if (rst) begin
      sb.delete();
      known = 1;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (do_out) void'(sb.pop_front());
      if (do_in) sb.push_back(pend);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    offer(64'hDEAD, 5'd3, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    chk("rst_result", result, 64'h0);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    tick();
    // branch conditions with flags from 2-4: Z0 N1 C0 V0
    out_ready = 1'b1;
    offer(64'd1, 5'd0, 1'b1, 3'b100, 4'b0100, 1'b1, 1'b0); tick();
    chk("blt_latency", 64'(out_valid), 64'h1);
    offer(64'd2, 5'd0, 1'b1, 3'b110, 4'b0100, 1'b1, 1'b0); tick();
    offer(64'd3, 5'd0, 1'b1, 3'b111, 4'b0100, 1'b0, 1'b0); tick();
    // signed overflow: Z0 N0 C1 V1
    offer(64'd4, 5'd0, 1'b1, 3'b100, 4'b0011, 1'b1, 1'b0); tick();
    offer(64'd5, 5'd0, 1'b1, 3'b101, 4'b0011, 1'b0, 1'b0); tick();
    offer(64'd6, 5'd0, 1'b1, 3'b111, 4'b0011, 1'b1, 1'b0); tick();
    offer(64'd7, 5'd0, 1'b1, 3'b000, 4'b1000, 1'b1, 1'b0); tick();
    offer(64'd8, 5'd0, 1'b1, 3'b001, 4'b1000, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick();
    // backpressure
    out_ready = 1'b0;
    offer(64'h19, 5'd1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    offer(64'h1, 5'd2, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    chk("bp_in_ready", 64'(in_ready), 64'h0);
    offer(64'h5, 5'd3, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick(); tick();
    chk("bp_held", result, 64'h19);
    out_ready = 1'b1;
    tick(); tick(); tick();
    chk("bp_last", result, 64'h5);
    in_valid = 1'b0; tick(); tick();
    // flush with both entries held and a new entry offered
    out_ready = 1'b0;
    offer(64'hA1, 5'd4, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    offer(64'hA2, 5'd5, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    offer(64'hA3, 5'd6, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0);
    flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_out_valid", 64'(out_valid), 64'h0);
    chk("flush_in_ready", 64'(in_ready), 64'h1);
    out_ready = 1'b1; tick(); tick();
    // illegal condition codes and non-branch entries
    offer(64'hB0, 5'd7, 1'b1, 3'b010, 4'b1111, 1'b0, 1'b1); tick();
    chk("illegal_flag", 64'(br_illegal), 64'h1);
    offer(64'hB1, 5'd8, 1'b1, 3'b011, 4'b1111, 1'b0, 1'b1); tick();
    offer(64'hB2, 5'd9, 1'b0, 3'b010, 4'b1111, 1'b0, 1'b0); tick();
    offer(64'hB3, 5'd10, 1'b0, 3'b000, 4'b1000, 1'b0, 1'b0); tick();
    in_valid = 1'b0; tick();
    // reset mid-operation discards held entries
    out_ready = 1'b0;
    offer(64'hC0, 5'd11, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    offer(64'hC1, 5'd12, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b0); tick();
    out_ready = 1'b1; flush = 1'b1; rst = 1'b1; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_result", result, 64'h0);
    tick(); tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
